// File: rtl/bus_pkg.sv
// Shared types and constants for the slave-bus arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: arbiter state enum, bus widths, slave-side request struct and its idle value.
package bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_t;

   // Everything a master drives toward the slave, bundled so the mux is one assignment.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wr_data;
      logic              we;
      logic [SEL_W-1:0]  sel;
      logic              strobe;
   } bus_req_t;

   localparam bus_req_t BUS_IDLE = '0;

   // Position k of a circular scan of n entries beginning at start.
   function automatic int rr_index(input int start, input int k, input int n);
      return (start + k) % n;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin winner search over a request vector.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is used.
// Ports: req (requests), start (first index scanned), exclude_low (requesters that only
//        win when no other requester is pending), winner (index), valid (any winner).
module rr_picker
   import bus_pkg::*;
#(
   parameter  int N  = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   input  logic [N-1:0]  exclude_low,
   output logic [IW-1:0] winner,
   output logic          valid
);

   always_comb begin
      logic [IW-1:0] idx;
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      // First pass: preferred requesters in circular order from start.
      for (int k = 0; k < N; k++) begin
         idx = IW'(rr_index(int'(start), k, N));
         if (!valid && req[idx] && !exclude_low[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
      // Second pass: demoted requesters only if nobody else asked.
      for (int k = 0; k < N; k++) begin
         idx = IW'(rr_index(int'(start), k, N));
         if (!valid && req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter + mux sharing one slave bus among NUM_MASTERS masters, with watchdog.
// Latency: req -> registered grant in 1 cycle; grant -> slave signals and ready -> m_ready combinational.
// Backpressure: owner holds the bus until s_ready, req withdrawal or watchdog; handover has no bubble.
// Ports: clk/rst (sync, active-high); m_* per-master request side; s_* slave side;
//        owner = granted index (valid while |m_grant); timeout_err = one-cycle forced-release pulse.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   parameter  int TIMEOUT     = 255,
   localparam int IW          = $clog2(NUM_MASTERS)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_MASTERS-1:0]              m_req,
   input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_addr,
   input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_wr_data,
   input  logic [NUM_MASTERS-1:0]              m_we,
   input  logic [NUM_MASTERS-1:0][SEL_W-1:0]   m_sel,
   input  logic [NUM_MASTERS-1:0]              m_as,
   output logic [NUM_MASTERS-1:0]              m_grant,
   output logic [NUM_MASTERS-1:0]              m_ready,
   output logic [DATA_W-1:0]                   m_rd_data,
   output logic [ADDR_W-1:0]                   s_addr,
   output logic [DATA_W-1:0]                   s_wr_data,
   output logic                                s_we,
   output logic                                s_as,
   output logic [SEL_W-1:0]                    s_sel,
   input  logic [DATA_W-1:0]                   s_rd_data,
   input  logic                                s_ready,
   output logic [IW-1:0]                       owner,
   output logic                                timeout_err
);

   localparam int            WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

   arb_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [IW-1:0]          last_owner_q, last_owner_d;
   logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
   logic                   timeout_err_q, timeout_err_d;

   logic [IW-1:0]          pick_start;
   logic [IW-1:0]          pick_idx;
   logic                   pick_vld;
   logic                   wd_expire;
   logic                   release_now;
   bus_req_t               sel_bus;

   // last_owner equals owner while OWNED, so one scan start serves both the idle
   // arbitration and the handover (current owner lands last in the circular order).
   assign pick_start = (last_owner_q == LAST_IDX) ? '0 : last_owner_q + IW'(1);

   rr_picker #(.N(NUM_MASTERS)) u_picker (
      .req         (m_req),
      .start       (pick_start),
      .exclude_low (grant_q),
      .winner      (pick_idx),
      .valid       (pick_vld)
   );

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      owner_d       = owner_q;
      last_owner_d  = last_owner_q;
      wd_cnt_d      = wd_cnt_q;
      timeout_err_d = 1'b0;

      wd_expire   = (TIMEOUT != 0) && (state_q == ARB_OWNED) &&
                    (wd_cnt_q == WD_LAST) && !s_ready;
      release_now = s_ready || !m_req[owner_q] || wd_expire;

      case (state_q)
         ARB_IDLE: begin
            wd_cnt_d = '0;
            if (pick_vld) begin
               state_d           = ARB_OWNED;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               owner_d           = pick_idx;
               last_owner_d      = pick_idx;
            end
         end
         ARB_OWNED: begin
            if (release_now) begin
               // Every release restarts the watchdog, including a re-grant to the same master.
               wd_cnt_d      = '0;
               timeout_err_d = wd_expire;
               grant_d       = '0;
               if (pick_vld) begin
                  grant_d[pick_idx] = 1'b1;
                  owner_d           = pick_idx;
                  last_owner_d      = pick_idx;
               end else begin
                  state_d = ARB_IDLE;
               end
            end else begin
               wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ARB_IDLE;
         grant_q       <= '0;
         owner_q       <= '0;
         last_owner_q  <= LAST_IDX;
         wd_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         owner_q       <= owner_d;
         last_owner_q  <= last_owner_d;
         wd_cnt_q      <= wd_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Slave-side mux driven from the registered grant; idle bus is all zeros.
   always_comb begin
      sel_bus = BUS_IDLE;
      if (|grant_q) begin
         sel_bus.addr    = m_addr[owner_q];
         sel_bus.wr_data = m_wr_data[owner_q];
         sel_bus.we      = m_we[owner_q];
         sel_bus.sel     = m_sel[owner_q];
         sel_bus.strobe  = m_as[owner_q];
      end
   end

   assign s_addr      = sel_bus.addr;
   assign s_wr_data   = sel_bus.wr_data;
   assign s_we        = sel_bus.we;
   assign s_sel       = sel_bus.sel;
   assign s_as        = sel_bus.strobe;
   assign m_grant     = grant_q;
   assign m_ready     = grant_q & {NUM_MASTERS{s_ready}};
   assign m_rd_data   = s_rd_data;
   assign owner       = owner_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a cycle-level reference model checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_bus_arbiter;

   localparam int N  = 2;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]       req_raw       = '0;
   logic [N-1:0]       drop_on_ready = '0;
   logic [N-1:0]       m_req;
   logic [N-1:0][31:0] m_addr    = '0;
   logic [N-1:0][31:0] m_wr_data = '0;
   logic [N-1:0]       m_we      = '0;
   logic [N-1:0][3:0]  m_sel     = '0;
   logic [N-1:0]       m_as      = '0;
   logic [N-1:0]       m_grant;
   logic [N-1:0]       m_ready;
   logic [31:0]        m_rd_data;
   logic [31:0]        s_addr;
   logic [31:0]        s_wr_data;
   logic               s_we;
   logic               s_as;
   logic [3:0]         s_sel;
   logic [31:0]        s_rd_data = '0;
   logic               s_ready   = 1'b0;
   logic [0:0]         owner;
   logic               timeout_err;

   // Masters optionally drop req combinationally on their own ready.
   always_comb m_req = req_raw & ~(drop_on_ready & m_ready);

   bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .m_req       (m_req),
      .m_addr      (m_addr),
      .m_wr_data   (m_wr_data),
      .m_we        (m_we),
      .m_sel       (m_sel),
      .m_as        (m_as),
      .m_grant     (m_grant),
      .m_ready     (m_ready),
      .m_rd_data   (m_rd_data),
      .s_addr      (s_addr),
      .s_wr_data   (s_wr_data),
      .s_we        (s_we),
      .s_as        (s_as),
      .s_sel       (s_sel),
      .s_rd_data   (s_rd_data),
      .s_ready     (s_ready),
      .owner       (owner),
      .timeout_err (timeout_err)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: owner index (-1 = nobody), previous winner, granted cycles without ready.
   int mo_owner = -1;
   int mo_last  = N - 1;
   int mo_age   = 0;
   bit mo_terr  = 1'b0;

   // First requester found scanning forward from the entry after 'after', wrapping.
   function automatic int first_after(input int after);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (after + k) % N;
         if (m_req[j]) return j;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      logic [31:0] eg;
      int          nxt;
      bit          expire;
      bit          rel;
      if (chk_en) begin
         eg = '0;
         if (mo_owner >= 0) eg[mo_owner] = 1'b1;
         chk("model m_grant", 32'(m_grant), eg);
         chk("model m_ready", 32'(m_ready), s_ready ? eg : 32'd0);
         chk("model m_rd_data", m_rd_data, s_rd_data);
         chk("model timeout_err", 32'(timeout_err), 32'(mo_terr));
         if (mo_owner >= 0) begin
            chk("model owner", 32'(owner), mo_owner);
            chk("model s_addr", s_addr, m_addr[mo_owner]);
            chk("model s_wr_data", s_wr_data, m_wr_data[mo_owner]);
            chk("model s_we", 32'(s_we), 32'(m_we[mo_owner]));
            chk("model s_sel", 32'(s_sel), 32'(m_sel[mo_owner]));
            chk("model s_as", 32'(s_as), 32'(m_as[mo_owner]));
         end else begin
            chk("model idle bus", {s_addr ^ s_wr_data, 31'd0} | 32'({s_we, s_as, s_sel}) | s_addr, 32'd0);
         end
      end
      // Advance to the state the coming rising edge must produce.
      if (rst) begin
         mo_owner = -1;
         mo_last  = N - 1;
         mo_age   = 0;
         mo_terr  = 1'b0;
      end else begin
         mo_terr = 1'b0;
         if (mo_owner < 0) begin
            nxt = first_after(mo_last);
            if (nxt >= 0) begin
               mo_owner = nxt;
               mo_last  = nxt;
               mo_age   = 0;
            end
         end else begin
            expire = (TO != 0) && (mo_age == TO - 1) && !s_ready;
            rel    = s_ready || !m_req[mo_owner] || expire;
            if (rel) begin
               mo_terr  = expire;
               nxt      = first_after(mo_owner);
               mo_owner = nxt;
               if (nxt >= 0) mo_last = nxt;
               mo_age   = 0;
            end else begin
               mo_age++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset m_grant", 32'(m_grant), 32'd0);
      chk("reset owner", 32'(owner), 32'd0);
      chk("reset timeout_err", 32'(timeout_err), 32'd0);
      rst = 1'b0;

      // Single master: req in cycle c, grant c+1, ready c+3, grant gone c+4.
      tick();
      req_raw   = 2'b01;
      m_addr[0] = 32'h0000_0100;
      m_as[0]   = 1'b1;
      tick();
      chk("single grant", 32'(m_grant), 32'h1);
      chk("single s_addr", s_addr, 32'h0000_0100);
      tick();
      tick();
      s_ready   = 1'b1;
      s_rd_data = 32'hDEAD_BEEF;
      req_raw   = 2'b00;
      #1;
      chk("single m_ready", 32'(m_ready), 32'h1);
      chk("single m_rd_data", m_rd_data, 32'hDEAD_BEEF);
      tick();
      s_ready = 1'b0;
      m_as    = '0;
      #1;
      chk("single grant drop", 32'(m_grant), 32'h0);

      // Simultaneous requests from reset, each master drops req on its ready.
      rst = 1'b1;
      tick();
      rst           = 1'b0;
      req_raw       = 2'b11;
      drop_on_ready = 2'b11;
      m_as          = 2'b11;
      tick();
      chk("simul first grant", 32'(m_grant), 32'h1);
      s_ready = 1'b1;
      tick();
      req_raw[0] = 1'b0;
      s_ready    = 1'b0;
      #1;
      chk("simul handover", 32'(m_grant), 32'h2);
      s_ready = 1'b1;
      tick();
      req_raw       = 2'b00;
      s_ready       = 1'b0;
      drop_on_ready = 2'b00;
      #1;
      chk("simul release", 32'(m_grant), 32'h0);

      // Contention: both hold req, slave ready every cycle -> strict alternation.
      m_addr[0] = 32'h0000_00A0;
      m_addr[1] = 32'h0000_00B0;
      req_raw   = 2'b11;
      tick();
      for (int t = 0; t < 6; t++) begin
         chk("fair owner", 32'(owner), t % 2);
         chk("fair s_addr", s_addr, (t % 2 == 1) ? 32'h0000_00B0 : 32'h0000_00A0);
         s_ready = 1'b1;
         tick();
      end
      s_ready = 1'b0;
      req_raw = 2'b00;
      tick();
      chk("fair release", 32'(m_grant), 32'h0);

      // Watchdog: slave silent, grant held TO cycles then handed to the other requester.
      req_raw = 2'b11;
      tick();
      for (int i = 0; i < TO; i++) begin
         chk("wd hold", 32'(m_grant), 32'h2);
         tick();
      end
      chk("wd handover", 32'(m_grant), 32'h1);
      chk("wd pulse", 32'(timeout_err), 32'h1);
      tick();
      chk("wd pulse end", 32'(timeout_err), 32'h0);
      req_raw = 2'b00;
      tick();

      // Reset while master 1 owns the bus.
      req_raw = 2'b10;
      m_we[1] = 1'b1;
      tick();
      chk("rst pre grant", 32'(m_grant), 32'h2);
      chk("rst pre s_we", 32'(s_we), 32'h1);
      req_raw = 2'b11;
      rst     = 1'b1;
      tick();
      chk("rst grant", 32'(m_grant), 32'h0);
      chk("rst s_we", 32'(s_we), 32'h0);
      rst = 1'b0;
      tick();
      chk("rst regrant", 32'(m_grant), 32'h1);
      req_raw = 2'b00;
      m_we    = '0;
      tick();

      // Write path from master 1.
      req_raw      = 2'b10;
      m_we[1]      = 1'b1;
      m_sel[1]     = 4'b0011;
      m_wr_data[1] = 32'h0000_1234;
      m_addr[1]    = 32'h0000_0044;
      tick();
      chk("wr grant", 32'(m_grant), 32'h2);
      chk("wr s_we", 32'(s_we), 32'h1);
      chk("wr s_sel", 32'(s_sel), 32'h3);
      chk("wr s_wr_data", s_wr_data, 32'h0000_1234);
      chk("wr s_addr", s_addr, 32'h0000_0044);
      tick();
      s_ready = 1'b1;
      req_raw = 2'b00;
      tick();
      s_ready = 1'b0;
      #1;
      chk("wr idle s_we", 32'(s_we), 32'h0);
      chk("wr idle s_sel", 32'(s_sel), 32'h0);
      chk("wr idle s_wr_data", s_wr_data, 32'h0);

      // Ready with nobody granted is ignored.
      s_ready = 1'b1;
      #1;
      chk("idle ready", 32'(m_ready), 32'h0);
      tick();
      s_ready = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
